// File: rtl/rotor_setting_bank_pkg.sv
// Shared constants and helpers for the rotor setting bank: digit count,
// per-digit wrap limits and the one-hot test used for step validity.
package rotor_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned DIGIT_W    = 8;
    localparam logic [DIGIT_W-1:0] WIDE_MAX   = 8'h30;
    localparam logic [DIGIT_W-1:0] NARROW_MAX = 8'h09;

    // Digits 0, 3 and 6 are the narrow (single decimal) positions.
    function automatic logic [DIGIT_W-1:0] digit_max(input logic [2:0] idx);
        logic [DIGIT_W-1:0] lim;
        lim = WIDE_MAX;
        if (idx == 3'd0 || idx == 3'd3 || idx == 3'd6) begin
            lim = NARROW_MAX;
        end
        return lim;
    endfunction

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

endpackage

// File: rtl/rotor_digit_cell.sv
// One rotor digit: edit and active registers, up/down stepping with wrap,
// and registered one-cycle step/wrap flags.
module rotor_digit_cell
    import rotor_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               sel,
    input  logic               inc,
    input  logic               dec,
    input  logic               commit,
    input  logic               revert,
    input  logic [DIGIT_W-1:0] max,
    output logic [DIGIT_W-1:0] edit_digit,
    output logic [DIGIT_W-1:0] active_digit,
    output logic               step_flag,
    output logic               wrap_flag
);

    logic [DIGIT_W-1:0] edit_reg;
    logic [DIGIT_W-1:0] active_reg;
    logic               step_reg;
    logic               wrap_reg;

    // sel arrives already qualified by the top: one-hot, exactly one
    // direction, and not overridden by a revert.
    always_ff @(posedge clock) begin
        if (reset) begin
            edit_reg   <= '0;
            active_reg <= '0;
            step_reg   <= 1'b0;
            wrap_reg   <= 1'b0;
        end else begin
            step_reg <= 1'b0;
            wrap_reg <= 1'b0;
            if (commit) begin
                active_reg <= edit_reg;
            end
            if (revert) begin
                edit_reg <= active_reg;
            end else if (sel && inc) begin
                step_reg <= 1'b1;
                if (edit_reg == max) begin
                    edit_reg <= '0;
                    wrap_reg <= 1'b1;
                end else begin
                    edit_reg <= edit_reg + 8'd1;
                end
            end else if (sel && dec) begin
                step_reg <= 1'b1;
                if (edit_reg == '0) begin
                    edit_reg <= max;
                    wrap_reg <= 1'b1;
                end else begin
                    edit_reg <= edit_reg - 8'd1;
                end
            end
        end
    end

    assign edit_digit   = edit_reg;
    assign active_digit = active_reg;
    assign step_flag    = step_reg;
    assign wrap_flag    = wrap_reg;

endmodule

// File: rtl/rotor_setting_bank.sv
// Eight-digit rotor setting bank with an editable bank, a committed bank
// read by the cipher core, and step/wrap/dirty status.
module rotor_setting_bank
    import rotor_pkg::*;
(
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_DIGITS-1:0]           rotor_sel,
    input  logic                            inc,
    input  logic                            dec,
    input  logic                            commit,
    input  logic                            revert,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   edit_digits,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   active_digits,
    output logic                            dirty,
    output logic                            step_done,
    output logic                            wrapped
);

    logic                  step_valid;
    logic                  revert_eff;
    logic                  step_apply;
    logic                  dirty_reg;
    logic [NUM_DIGITS-1:0] step_flags;
    logic [NUM_DIGITS-1:0] wrap_flags;

    // commit beats revert; revert beats a step.
    assign step_valid = is_onehot8(rotor_sel) && (inc ^ dec);
    assign revert_eff = revert && !commit;
    assign step_apply = step_valid && !revert_eff;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_cell
            rotor_digit_cell u_cell (
                .clock        (clock),
                .reset        (reset),
                .sel          (rotor_sel[gi] && step_apply),
                .inc          (inc),
                .dec          (dec),
                .commit       (commit),
                .revert       (revert_eff),
                .max          (digit_max(3'(gi))),
                .edit_digit   (edit_digits[gi*DIGIT_W +: DIGIT_W]),
                .active_digit (active_digits[gi*DIGIT_W +: DIGIT_W]),
                .step_flag    (step_flags[gi]),
                .wrap_flag    (wrap_flags[gi])
            );
        end
    endgenerate

    // A step in the same cycle as a commit leaves the bank dirty.
    always_ff @(posedge clock) begin
        if (reset) begin
            dirty_reg <= 1'b0;
        end else if (step_apply) begin
            dirty_reg <= 1'b1;
        end else if (commit || revert) begin
            dirty_reg <= 1'b0;
        end
    end

    assign dirty     = dirty_reg;
    assign step_done = |step_flags;
    assign wrapped   = |wrap_flags;

endmodule

// File: tb/tb_rotor_setting_bank.sv
// Scoreboard bench for rotor_setting_bank: a behavioural model pushes the
// expected outputs per cycle, and they are popped and compared after the edge.
module tb_rotor_setting_bank;

    logic        clock;
    logic        reset;
    logic [7:0]  rotor_sel;
    logic        inc;
    logic        dec;
    logic        commit;
    logic        revert;
    logic [63:0] edit_digits;
    logic [63:0] active_digits;
    logic        dirty;
    logic        step_done;
    logic        wrapped;

    rotor_setting_bank dut (
        .clock         (clock),
        .reset         (reset),
        .rotor_sel     (rotor_sel),
        .inc           (inc),
        .dec           (dec),
        .commit        (commit),
        .revert        (revert),
        .edit_digits   (edit_digits),
        .active_digits (active_digits),
        .dirty         (dirty),
        .step_done     (step_done),
        .wrapped       (wrapped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] edit;
        logic [63:0] active;
        logic        dirty;
        logic        step_done;
        logic        wrapped;
    } exp_t;

    exp_t exp_q[$];

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [7:0] m_edit   [8];
    logic [7:0] m_active [8];
    logic       m_dirty;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] lim_of(input int i);
        return (i == 0 || i == 3 || i == 6) ? 8'h09 : 8'h30;
    endfunction

    function automatic logic [63:0] pack(input logic [7:0] a [8]);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = a[i];
        return v;
    endfunction

    // Advance the model by one edge and queue what the DUT should show.
    task automatic model_step(input logic rst, input logic [7:0] sel, input logic i_inc,
                              input logic i_dec, input logic i_com, input logic i_rev);
        exp_t e;
        logic [7:0] n_edit [8];
        logic [7:0] n_act  [8];
        int   idx;
        int   ones;
        logic valid;
        logic wrap;
        wrap = 1'b0;
        ones = 0;
        idx  = 0;
        for (int i = 0; i < 8; i++) if (sel[i]) begin ones++; idx = i; end
        valid = (ones == 1) && (i_inc != i_dec);
        for (int i = 0; i < 8; i++) begin
            n_edit[i] = m_edit[i];
            n_act[i]  = m_active[i];
        end
        if (rst) begin
            for (int i = 0; i < 8; i++) begin n_edit[i] = 8'h00; n_act[i] = 8'h00; end
            m_dirty = 1'b0;
            valid = 1'b0;
        end else begin
            if (i_com) for (int i = 0; i < 8; i++) n_act[i] = m_edit[i];
            if (i_rev && !i_com) begin
                for (int i = 0; i < 8; i++) n_edit[i] = m_active[i];
                valid = 1'b0;
            end else if (valid) begin
                if (i_inc) begin
                    if (m_edit[idx] == lim_of(idx)) begin n_edit[idx] = 8'h00; wrap = 1'b1; end
                    else n_edit[idx] = m_edit[idx] + 8'd1;
                end else begin
                    if (m_edit[idx] == 8'h00) begin n_edit[idx] = lim_of(idx); wrap = 1'b1; end
                    else n_edit[idx] = m_edit[idx] - 8'd1;
                end
            end
            if (valid) m_dirty = 1'b1;
            else if (i_com || i_rev) m_dirty = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            m_edit[i]   = n_edit[i];
            m_active[i] = n_act[i];
        end
        e.edit      = pack(m_edit);
        e.active    = pack(m_active);
        e.dirty     = m_dirty;
        e.step_done = valid;
        e.wrapped   = valid && wrap;
        exp_q.push_back(e);
    endtask

    // One cycle: drive on the falling edge, compare 1 time unit after the rise.
    task automatic cycle(input logic rst, input logic [7:0] sel, input logic i_inc,
                         input logic i_dec, input logic i_com, input logic i_rev);
        exp_t e;
        @(negedge clock);
        reset = rst; rotor_sel = sel; inc = i_inc; dec = i_dec; commit = i_com; revert = i_rev;
        model_step(rst, sel, i_inc, i_dec, i_com, i_rev);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            check_val("queue_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check_val("edit_digits", edit_digits, e.edit);
            check_val("active_digits", active_digits, e.active);
            check_val("dirty", {63'd0, dirty}, {63'd0, e.dirty});
            check_val("step_done", {63'd0, step_done}, {63'd0, e.step_done});
            check_val("wrapped", {63'd0, wrapped}, {63'd0, e.wrapped});
        end
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] rsel;
        reset = 1'b1; rotor_sel = 8'h00; inc = 1'b0; dec = 1'b0; commit = 1'b0; revert = 1'b0;
        for (int i = 0; i < 8; i++) begin m_edit[i] = 8'h00; m_active[i] = 8'h00; end
        m_dirty = 1'b0;

        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("reset_edit", edit_digits, 64'd0);
        check_val("reset_active", active_digits, 64'd0);

        // Narrow digit 0 counts 1..9 then wraps to 0 on the tenth step.
        for (int k = 0; k < 10; k++) cycle(1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("d0_wrap_value", {56'd0, edit_digits[7:0]}, 64'd0);
        check_val("d0_wrap_pulse", {63'd0, wrapped}, 64'd1);
        idle();

        // Wide digit 1 decrements from 0 to its limit.
        cycle(1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("d1_dec_wrap", {56'd0, edit_digits[15:8]}, 64'h30);

        // Invalid steps: multi-hot select, and both directions at once.
        cycle(1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Digit 7 to 5, commit, then revert.
        for (int k = 0; k < 5; k++) cycle(1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("d7_committed", {56'd0, active_digits[63:56]}, 64'h05);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("banks_equal", edit_digits, active_digits);

        // Edit digit 0 to 3 then revert it away.
        for (int k = 0; k < 3; k++) cycle(1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("d0_reverted", {56'd0, edit_digits[7:0]}, 64'd0);

        // Commit in the same cycle as a step on digit 3 (edit value 2).
        cycle(1'b0, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 8'h08, 1'b1, 1'b0, 1'b1, 1'b0);
        check_val("d3_active_pre", {56'd0, active_digits[31:24]}, 64'h02);
        check_val("d3_edit_post", {56'd0, edit_digits[31:24]}, 64'h03);
        check_val("d3_dirty", {63'd0, dirty}, 64'd1);

        // Revert with a step, and commit with revert.
        cycle(1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

        // Mid-edit reset together with an inc.
        cycle(1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("reset_mid_edit", edit_digits, 64'd0);
        idle();

        // Randomised traffic, biased toward valid steps.
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 9))
                0:       rsel = 8'h00;
                1:       rsel = 8'($urandom);
                default: rsel = 8'h01 << $urandom_range(0, 7);
            endcase
            cycle($urandom_range(0, 99) == 0, rsel,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
